// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared wave codes, pipeline latency and midscale helper for the DDS core
package dds_pkg;

  localparam logic [2:0] WAVE_SINE   = 3'd0;
  localparam logic [2:0] WAVE_SQUARE = 3'd1;
  localparam logic [2:0] WAVE_TRI    = 3'd2;
  localparam logic [2:0] WAVE_SAW    = 3'd3;

  // Clock edges from the apply edge to the first sample of the new setting
  localparam int DDS_LAT = 3;

  function automatic int dds_midscale(input int data_w);
    return 1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/dds_sine_qrom.sv
// rtl/dds_sine_qrom.sv - quarter-wave sine magnitude ROM with registered read
module dds_sine_qrom #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  // Table entry k samples the quarter wave at the centre of bin k, so the
  // mirrored second quarter needs no extra offset.
  function automatic logic [DATA_W-1:0] rom_val(input int k);
    real x;
    real term;
    real s;
    x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(DEPTH);
    s    = x;
    term = x;
    for (int n = 1; n < 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return DATA_W'($rtoi(real'((1 << DATA_W) - 1) * s + 0.5));
  endfunction

  logic [DATA_W-1:0] rom_tab [DEPTH];
  logic [DATA_W-1:0] data_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [DATA_W-1:0] VAL = rom_val(k);
    assign rom_tab[k] = VAL;
  end

  // Registered table read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= rom_tab[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/dds_wave_gen.sv
// rtl/dds_wave_gen.sv - phase-accumulator DDS core (optional phase dither via DDS_DITHER_EN)
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         wave_sel_in,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic               dds_apply_pulse,
  output logic [DATA_W-1:0]  dac_data,
  output logic               dac_valid,
  output logic               wrap_pulse,
  output logic               apply_ack
);

  localparam int QA_W = ADDR_W - 2;
  localparam logic [DATA_W-1:0] MID = DATA_W'(dds_midscale(DATA_W));

  logic [2:0]         sel_q;
  logic [PHASE_W-1:0] ftw_q;
  logic [PHASE_W-1:0] phase_q;
  logic               armed_q;
  logic [PHASE_W:0]   sum_d;
  logic [DDS_LAT-1:0] ack_pipe_q;
  logic [DDS_LAT-1:0] wrap_pipe_q;
  logic [DDS_LAT-1:0] arm_pipe_q;

  // Top phase bits: MSB (half), next bit (quarter), then sample bits
  logic [DATA_W:0]    ptop_d;
  logic [QA_W-1:0]    q_d;
  logic [QA_W-1:0]    addr_d;
  logic [DATA_W-1:0]  val_d;
  logic               is_sine_d;

  logic [QA_W-1:0]    addr1_q;
  logic [DATA_W-1:0]  val1_q;
  logic               sine1_q;
  logic               neg1_q;
  logic [DATA_W-1:0]  val2_q;
  logic               sine2_q;
  logic               neg2_q;
  logic [DATA_W-2:0]  rom_data;
  logic [DATA_W-1:0]  mag;

  logic [DATA_W-1:0]  dac_q;
  logic               valid_q;
  logic               wrap_q;
  logic               ack_q;

  assign sum_d = {1'b0, phase_q} + {1'b0, ftw_q};

  // Setting latch and phase accumulator; an apply restarts the phase at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      ftw_q   <= '0;
      phase_q <= '0;
      armed_q <= 1'b0;
    end else if (dds_apply_pulse) begin
      sel_q   <= wave_sel_in;
      ftw_q   <= ftw_in;
      phase_q <= '0;
      armed_q <= 1'b1;
    end else begin
      phase_q <= sum_d[PHASE_W-1:0];
    end
  end

  // Side-band flags ride alongside the sample so they line up at the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pipe_q  <= '0;
      wrap_pipe_q <= '0;
      arm_pipe_q  <= '0;
    end else begin
      ack_pipe_q  <= {ack_pipe_q[DDS_LAT-2:0], dds_apply_pulse};
      wrap_pipe_q <= {wrap_pipe_q[DDS_LAT-2:0], dds_apply_pulse | sum_d[PHASE_W]};
      arm_pipe_q  <= {arm_pipe_q[DDS_LAT-2:0], dds_apply_pulse | armed_q};
    end
  end

`ifdef DDS_DITHER_EN
  localparam int DITH_W = PHASE_W - ADDR_W - 2;
  logic [15:0]        lfsr_q;
  logic [PHASE_W-1:0] dith_d;
  logic [PHASE_W-1:0] pdith_d;

  // Galois LFSR x^16+x^14+x^13+x^11+1, free running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Dither sits below the LUT resolution; square only looks at the MSB so it stays clean
  always_comb begin
    dith_d = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < DITH_W) dith_d[i] = lfsr_q[i];
    end
    pdith_d = (sel_q == WAVE_SQUARE) ? phase_q : phase_q + dith_d;
    ptop_d  = pdith_d[PHASE_W-1 -: DATA_W+1];
  end
`else
  assign ptop_d = phase_q[PHASE_W-1 -: DATA_W+1];
`endif

  // Waveform decode and quarter-wave address for the sine path
  always_comb begin
    q_d       = ptop_d[DATA_W-2 -: QA_W];
    addr_d    = ptop_d[DATA_W-1] ? ~q_d : q_d;
    is_sine_d = 1'b0;
    val_d     = MID;
    case (sel_q)
      WAVE_SINE:   is_sine_d = 1'b1;
      WAVE_SQUARE: val_d = ptop_d[DATA_W] ? '0 : '1;
      WAVE_TRI:    val_d = ptop_d[DATA_W] ? ~ptop_d[DATA_W-1:0] : ptop_d[DATA_W-1:0];
      WAVE_SAW:    val_d = ptop_d[DATA_W -: DATA_W];
      default:     val_d = MID;
    endcase
  end

  // Stage 1: register decode results and ROM address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr1_q <= '0;
      val1_q  <= '0;
      sine1_q <= 1'b0;
      neg1_q  <= 1'b0;
    end else begin
      addr1_q <= addr_d;
      val1_q  <= val_d;
      sine1_q <= is_sine_d;
      neg1_q  <= ptop_d[DATA_W];
    end
  end

  dds_sine_qrom #(
    .ADDR_W (QA_W),
    .DATA_W (DATA_W - 1)
  ) u_qrom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (addr1_q),
    .data_o (rom_data)
  );

  // Stage 2: carry decode results alongside the registered ROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val2_q  <= '0;
      sine2_q <= 1'b0;
      neg2_q  <= 1'b0;
    end else begin
      val2_q  <= val1_q;
      sine2_q <= sine1_q;
      neg2_q  <= neg1_q;
    end
  end

  assign mag = DATA_W'(rom_data);

  // Output register; samples are held at midscale until the first setting arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_q   <= MID;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      if (arm_pipe_q[DDS_LAT-1]) begin
        dac_q <= sine2_q ? (neg2_q ? MID - DATA_W'(1) - mag : MID + mag) : val2_q;
      end
      valid_q <= arm_pipe_q[DDS_LAT-1];
      wrap_q  <= wrap_pipe_q[DDS_LAT-1];
      ack_q   <= ack_pipe_q[DDS_LAT-1];
    end
  end

  assign dac_data   = dac_q;
  assign dac_valid  = valid_q;
  assign wrap_pulse = wrap_q;
  assign apply_ack  = ack_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb/tb_dds_wave_gen.sv - randomized self-checking bench for dds_wave_gen against an arithmetic reference
module tb_dds_wave_gen;

  logic        clk;
  logic        rst_n;
  logic [2:0]  wave_sel_in;
  logic [31:0] ftw_in;
  logic        dds_apply_pulse;
  logic [11:0] dac_data;
  logic        dac_valid;
  logic        wrap_pulse;
  logic        apply_ack;

  int vec_cnt;
  int err_cnt;
  int samp [0:2047];
  logic [2:0]  sel_a [4];
  logic [31:0] ftw_a [4];

  dds_wave_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wave_sel_in     (wave_sel_in),
    .ftw_in          (ftw_in),
    .dds_apply_pulse (dds_apply_pulse),
    .dac_data        (dac_data),
    .dac_valid       (dac_valid),
    .wrap_pulse      (wrap_pulse),
    .apply_ack       (apply_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample value at a given phase, straight from the waveform definitions
  function automatic int ref_sample(input logic [2:0] sel, input logic [31:0] p);
    logic [7:0]  q;
    logic [11:0] t;
    int          r;
    real         x;
    case (sel)
      3'd0: begin
        q = p[29:22];
        if (p[30]) q = ~q;
        x = (real'(q) + 0.5) / 256.0 * 1.5707963267948966;
        r = $rtoi(2047.0 * $sin(x) + 0.5);
        return p[31] ? 2047 - r : 2048 + r;
      end
      3'd1: return p[31] ? 0 : 4095;
      3'd2: begin
        t = p[30:19];
        if (p[31]) t = ~t;
        return int'(t);
      end
      3'd3: return int'(p[31:20]);
      default: return 2048;
    endcase
  endfunction

  // Applies cnt settings on consecutive edges, then follows the last one for nsamp more samples
  task automatic run_seq(input int cnt, input int nsamp, input string tag);
    int total;
    int j;
    int k;
    int s;
    int n;
    logic [63:0] pr;
    logic [63:0] pp;
    logic        exp_wrap;
    total = cnt + 3 + nsamp;
    for (int e = 0; e <= total; e++) begin
      @(negedge clk);
      if (e > 0) begin
        j = e - 1;
        if (j < 3) begin
          chk({tag, "/ack_latency"}, 32'(apply_ack), 32'd0);
        end else begin
          k = j - 3;
          if (k < cnt) begin s = k; n = 0; end
          else begin s = cnt - 1; n = k - cnt + 1; end
          pr = 64'(n) * 64'(ftw_a[s]);
          pp = (n == 0) ? 64'd0 : 64'(n - 1) * 64'(ftw_a[s]);
          exp_wrap = (n == 0) || (pr[63:32] != pp[63:32]);
          if (n < 2048 && s == cnt - 1) samp[n] = int'(dac_data);
          chk({tag, "/data"}, 32'(dac_data), 32'(ref_sample(sel_a[s], pr[31:0])));
          chk({tag, "/valid"}, 32'(dac_valid), 32'd1);
          chk({tag, "/ack"}, 32'(apply_ack), 32'(n == 0));
          chk({tag, "/wrap"}, 32'(wrap_pulse), 32'(exp_wrap));
        end
      end
      if (e < cnt) begin
        wave_sel_in     = sel_a[e];
        ftw_in          = ftw_a[e];
        dds_apply_pulse = 1'b1;
      end else begin
        dds_apply_pulse = 1'b0;
        wave_sel_in     = 3'($urandom);
        ftw_in          = $urandom;
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/data"}, 32'(dac_data), 32'd2048);
    chk({tag, "/valid"}, 32'(dac_valid), 32'd0);
    chk({tag, "/ack"}, 32'(apply_ack), 32'd0);
    chk({tag, "/wrap"}, 32'(wrap_pulse), 32'd0);
  endtask

  task automatic run_one(input logic [2:0] sel, input logic [31:0] ftw, input int nsamp, input string tag);
    sel_a[0] = sel;
    ftw_a[0] = ftw;
    run_seq(1, nsamp, tag);
  endtask

  initial begin
    int cnt;
    vec_cnt         = 0;
    err_cnt         = 0;
    rst_n           = 1'b0;
    dds_apply_pulse = 1'b0;
    wave_sel_in     = 3'd0;
    ftw_in          = 32'd0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

    // Idle after reset: midscale, invalid, no pulses, even with inputs wiggling
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_idle("idle");
      wave_sel_in = 3'($urandom);
      ftw_in      = $urandom;
    end

    run_one(3'd3, 32'h0100_0000, 600, "saw");
    run_one(3'd1, 32'h0100_0000, 512, "square");

    run_one(3'd0, 32'h0040_0000, 1023, "sine");
    chk("sine/first", 32'(samp[0]), 32'd2054);
    chk("sine/peak", 32'(samp[255]), 32'd4095);
    chk("sine/min", 32'(samp[767]), 32'd0);
    for (int i = 0; i < 512; i += 37) begin
      chk("sine/symmetry", 32'(samp[i] + samp[i + 512]), 32'd4095);
    end

    run_one(3'd2, 32'd0, 40, "tri_ftw0");
    for (int i = 0; i < 40; i += 13) chk("tri_ftw0/const", 32'(samp[i]), 32'd0);

    // Reset in the middle of a sawtooth
    run_one(3'd3, 32'h0100_0000, 100, "saw_pre_rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    repeat (2) @(negedge clk);
    chk_idle("rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle("post_rst");
    end
    run_one(3'd3, 32'h0100_0000, 300, "saw_post_rst");

    // Back-to-back applies
    for (int i = 0; i < 3; i++) begin
      sel_a[i] = 3'($urandom_range(0, 7));
      ftw_a[i] = $urandom;
    end
    run_seq(3, 200, "burst");

    // Random settings, occasionally a pair of consecutive applies
    for (int r = 0; r < 8; r++) begin
      cnt = ($urandom_range(0, 3) == 0) ? 2 : 1;
      for (int i = 0; i < cnt; i++) begin
        sel_a[i] = 3'($urandom_range(0, 7));
        ftw_a[i] = $urandom >> $urandom_range(0, 24);
      end
      run_seq(cnt, $urandom_range(50, 300), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dds_wave_gen.md
Name: dds_wave_gen

Overview:
Phase-accumulator DDS core that consumes the latched waveform select, frequency tuning word and one-cycle apply strobe from the DDS state-control block. Streams one unsigned, offset-binary sample per clock to the DAC interface. Supports sine (quarter-wave ROM), square, triangle and sawtooth. A new setting takes effect only on the apply strobe, with a phase restart.

Parameters:
PHASE_W, 32, phase accumulator and FTW width
ADDR_W, 10, full-period LUT address bits; quarter ROM depth is 2^(ADDR_W-2)
DATA_W, 12, output sample width, unsigned offset binary, midscale 2^(DATA_W-1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
wave_sel_in  in  3  waveform code, sampled only on dds_apply_pulse
ftw_in  in  PHASE_W  frequency tuning word, sampled only on dds_apply_pulse
dds_apply_pulse  in  1  one-cycle apply strobe
dac_data  out  DATA_W  output sample
dac_valid  out  1  dac_data carries a generated waveform
wrap_pulse  out  1  one-cycle pulse aligned with the sample at phase 0 of each period
apply_ack  out  1  one-cycle pulse aligned with the first sample of the new setting

Behaviour:
- Reset values:
  - active_sel=0, active_ftw=0, phase_acc=0, armed=0.
  - All pipeline registers cleared.
  - dac_data=midscale (2048 for DATA_W=12).
  - dac_valid=0, wrap_pulse=0, apply_ack=0.
- Apply cycle (dds_apply_pulse=1 at a clock edge):
  - active_sel<=wave_sel_in, active_ftw<=ftw_in, phase_acc<=0, armed<=1.
- Other cycles:
  - phase_acc<=phase_acc+active_ftw, modulo 2^PHASE_W.
  - The carry-out flags the next sample as a wrap.
- Pipeline (3 stages):
  - S0: phase_acc.
  - S1: waveform decode and ROM address; ROM is a registered read.
  - S2: dac_data register.
  - The first sample of a new setting (phase 0) appears on dac_data 3 cycles after the apply edge.
  - apply_ack and wrap_pulse are delayed through the same 3 stages, so they align with that sample.
- Waveform codes (p = phase_acc):
  - 0 sine: q = p[PHASE_W-3 -: ADDR_W-2], mirrored (~q) when p[PHASE_W-2]=1.
    - Positive half (p[MSB]=0): midscale+rom[q].
    - Negative half: midscale-1-rom[q].
    - rom[k] = round((2^(DATA_W-1)-1) * sin(pi/2 * (k+0.5)/2^(ADDR_W-2))).
  - 1 square: p[MSB] ? 0 : all-ones.
  - 2 triangle: t = p[PHASE_W-2 -: DATA_W]; output p[MSB] ? ~t : t.
  - 3 sawtooth: p[PHASE_W-1 -: DATA_W].
  - 4-7: output held at midscale (mute); dac_valid still 1.
- dac_valid: 0 until the first apply_ack after reset, then 1 permanently until reset.
- ftw=0: phase frozen at 0 and output constant. wrap_pulse fires only for the apply sample.
- Apply asserted on consecutive cycles: each edge reloads and zeroes the phase. apply_ack is produced for every asserted cycle.
- Inputs change without an apply: ignored.
- Reset mid-stream: immediate return to reset values. dac_valid stays 0 until the next apply.

Optional Feature:
DDS_DITHER_EN:
- Defined: a 16-bit Galois LFSR (poly x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) adds its low (PHASE_W-ADDR_W-2) bits to the phase before truncation. The adder is not applied in square mode. The LFSR advances every cycle; latency is unchanged.
- Undefined: no LFSR; plain truncation.

Decomposition:
- Package dds_pkg:
  - Wave codes WAVE_SINE=3'd0, WAVE_SQUARE=3'd1, WAVE_TRI=3'd2, WAVE_SAW=3'd3.
  - Pipeline latency constant DDS_LAT=3.
  - Midscale function.
- Sub-module dds_sine_qrom: quarter-wave ROM with a registered read, generated from the formula above.

Test Plan:
- Reset, then idle for 20 cycles -> dac_data=2048, dac_valid=0, no pulses.
- Apply sel=3, ftw=2^24 ->
  - 3 cycles later: apply_ack=1, dac_valid rises, dac_data=0.
  - Then +16 per clock up to 4080.
  - wrap_pulse every 256 cycles.
- Apply sel=1, ftw=2^24 -> 128 samples of 4095 followed by 128 samples of 0, repeating.
- Apply sel=0, ftw=2^22 (1024-cycle period) ->
  - First sample 2054.
  - Peak 4095 at sample ~255.
  - Minimum 0 near sample 767.
  - Output is half-wave symmetric about 2047.5.
- Change ftw_in/wave_sel_in without an apply -> output unchanged. Then apply sel=2, ftw=0 -> constant 0 after 3 cycles; wrap_pulse occurs once only.
- Assert rst_n low mid-sawtooth -> outputs return to reset values immediately. A subsequent apply restarts at phase 0 with 3-cycle latency.
